// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the baud divisor helper
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_PAR   = 3'd3,
    RX_STOP  = 3'd4,
    RX_BRK   = 3'd5
  } rx_state_e;

  // Rounded clocks-per-oversample-tick.
  function automatic int uart_div(input longint clk_hz, input longint baud, input longint os);
    longint den;
    den = baud * os;
    return int'((clk_hz + den / 64'd2) / den);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle tick every DIV clocks, realigned by a synchronous restart.
module uart_tick_gen #(
  parameter int DIV = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (restart) begin
      cnt_d  = {CW{1'b0}};
      tick_d = 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_d  = {CW{1'b0}};
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + ONE;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver with majority voting, parity/stop checking, break and overrun
// detection, and a valid/ready output holding one word.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int OVERSAMPLE = 8,
  parameter int SYNC_DEPTH = 3,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun_err,
  output logic                 break_det
);

  localparam int     DIV      = uart_div(CLK_HZ, BAUDRATE, OVERSAMPLE);
  localparam longint BIT_BAUD = longint'(DIV) * longint'(OVERSAMPLE) * longint'(BAUDRATE);
  localparam longint CLK_L    = longint'(CLK_HZ);
  localparam longint ERR_ABS  = (CLK_L > BIT_BAUD) ? (CLK_L - BIT_BAUD) : (BIT_BAUD - CLK_L);

  if (DIV < 1) begin : g_div_err
    $error("uart_receiver: baud divisor below 1");
  end
  if (ERR_ABS * 64'd50 > BIT_BAUD) begin : g_rate_err
    $error("uart_receiver: bit-rate error exceeds 2 percent");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0) || (SYNC_DEPTH < 2) || (DATA_BITS < 5) ||
      (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_param_err
    $error("uart_receiver: parameter out of range");
  end

  localparam int            SW     = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_PRE  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_POST = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    B_LAST = 4'(DATA_BITS - 1);
  localparam logic          SC_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam parity_e       PMODE  = parity_e'(2'(PARITY));

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic par_err(input logic [DATA_BITS-1:0] d, input logic p);
    logic x;
    x = ^{d, p};
    case (PMODE)
      PAR_ODD:  return ~x;
      PAR_EVEN: return x;
      default:  return 1'b0;
    endcase
  endfunction

  logic [SYNC_DEPTH-1:0] sync_q, sync_d, flush_q, flush_d;
  logic                  armed_q, armed_d, rxs_prev_q, rxs_prev_d;
  rx_state_e             state_q, state_d;
  logic [SW-1:0]         samp_q, samp_d, hcnt_q, hcnt_d;
  logic [1:0]            vote_q, vote_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [3:0]            bcnt_q, bcnt_d;
  logic                  pbit_q, pbit_d, ferr_q, ferr_d, scnt_q, scnt_d;
  logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
  logic                  rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d, rx_valid_q, rx_valid_d;
  logic                  overrun_q, overrun_d, break_q, break_d;

  logic          rxs_s, tick_s, restart_s, start_edge_s, mid_s, bit_s;
  logic          complete_s, brk_s, frame_err_s;
  logic [SW-1:0] sidx_s;

  assign rxs_s = sync_q[SYNC_DEPTH-1];

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart_s),
    .tick    (tick_s)
  );

  // The synchroniser resets high, so the line only counts once real samples have flushed through it.
  always_comb begin
    sync_d       = {sync_q[SYNC_DEPTH-2:0], uart_rx};
    flush_d      = {flush_q[SYNC_DEPTH-2:0], 1'b1};
    armed_d      = armed_q | (flush_q[SYNC_DEPTH-1] & rxs_s);
    rxs_prev_d   = rxs_s;
    start_edge_s = armed_q & rxs_prev_q & ~rxs_s;
    sidx_s       = (samp_q == S_LAST) ? {SW{1'b0}} : (samp_q + S_ONE);
    mid_s        = tick_s && (sidx_s == S_POST);
    bit_s        = maj3(vote_q[0], vote_q[1], rxs_s);
  end

  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    vote_d      = vote_q;
    shift_d     = shift_q;
    bcnt_d      = bcnt_q;
    pbit_d      = pbit_q;
    ferr_d      = ferr_q;
    scnt_d      = scnt_q;
    hcnt_d      = hcnt_q;
    restart_s   = 1'b0;
    complete_s  = 1'b0;
    brk_s       = 1'b0;
    frame_err_s = ferr_q | ~bit_s;

    if (tick_s) begin
      samp_d = sidx_s;
      if (sidx_s == S_PRE) begin
        vote_d[0] = rxs_s;
      end else if (sidx_s == S_MID) begin
        vote_d[1] = rxs_s;
      end else begin
        vote_d = vote_q;
      end
    end else begin
      samp_d = samp_q;
    end

    // Every decision is taken at the M+1 sample, so the counter keeps its phase across bits.
    case (state_q)
      RX_IDLE: begin
        if (start_edge_s) begin
          restart_s = 1'b1;
          samp_d    = {SW{1'b0}};
          bcnt_d    = 4'd0;
          scnt_d    = 1'b0;
          ferr_d    = 1'b0;
          pbit_d    = 1'b0;
          state_d   = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (mid_s) begin
          state_d = bit_s ? RX_IDLE : RX_DATA;
        end else begin
          state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (mid_s) begin
          shift_d = {bit_s, shift_q[DATA_BITS-1:1]};
          if (bcnt_q == B_LAST) begin
            bcnt_d  = 4'd0;
            state_d = (PMODE == PAR_NONE) ? RX_STOP : RX_PAR;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end else begin
          state_d = RX_DATA;
        end
      end
      RX_PAR: begin
        if (mid_s) begin
          pbit_d  = bit_s;
          state_d = RX_STOP;
        end else begin
          state_d = RX_PAR;
        end
      end
      RX_STOP: begin
        if (mid_s) begin
          if (!scnt_q && !bit_s && (shift_q == {DATA_BITS{1'b0}}) &&
              ((PMODE == PAR_NONE) || !pbit_q)) begin
            brk_s   = 1'b1;
            hcnt_d  = {SW{1'b0}};
            state_d = RX_BRK;
          end else if (scnt_q == SC_LAST) begin
            complete_s = 1'b1;
            state_d    = RX_IDLE;
          end else begin
            ferr_d = frame_err_s;
            scnt_d = 1'b1;
          end
        end else begin
          state_d = RX_STOP;
        end
      end
      RX_BRK: begin
        if (!rxs_s) begin
          hcnt_d = {SW{1'b0}};
        end else if (tick_s) begin
          if (hcnt_q == S_LAST) begin
            hcnt_d  = {SW{1'b0}};
            state_d = RX_IDLE;
          end else begin
            hcnt_d = hcnt_q + S_ONE;
          end
        end else begin
          hcnt_d = hcnt_q;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    break_d    = brk_s;
    if (complete_s) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_perr_d  = par_err(shift_q, pbit_q);
        rx_ferr_d  = frame_err_s;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= {SYNC_DEPTH{1'b1}};
      flush_q    <= {SYNC_DEPTH{1'b0}};
      armed_q    <= 1'b0;
      rxs_prev_q <= 1'b1;
      state_q    <= RX_IDLE;
      samp_q     <= {SW{1'b0}};
      hcnt_q     <= {SW{1'b0}};
      vote_q     <= 2'b11;
      shift_q    <= {DATA_BITS{1'b0}};
      bcnt_q     <= 4'd0;
      pbit_q     <= 1'b0;
      ferr_q     <= 1'b0;
      scnt_q     <= 1'b0;
      rx_data_q  <= {DATA_BITS{1'b0}};
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      flush_q    <= flush_d;
      armed_q    <= armed_d;
      rxs_prev_q <= rxs_prev_d;
      state_q    <= state_d;
      samp_q     <= samp_d;
      hcnt_q     <= hcnt_d;
      vote_q     <= vote_d;
      shift_q    <= shift_d;
      bcnt_q     <= bcnt_d;
      pbit_q     <= pbit_d;
      ferr_q     <= ferr_d;
      scnt_q     <= scnt_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      break_q    <= break_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_valid      = rx_valid_q;
  assign overrun_err   = overrun_q;
  assign break_det     = break_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: an 8N1 instance and an 8E1 instance driven with
// hand-built frames; received words are captured at the handshake and compared to a table.
module tb_uart_receiver;

  localparam int BIT = 104;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       rdy0 = 1'b1, rdy1 = 1'b1;
  logic [7:0] data0, data1;
  logic       perr0, perr1, ferr0, ferr1, val0, val1, ovr0_s, ovr1_s, brk0_s, brk1_s;

  int n_vec = 0;
  int n_err = 0;
  int vcyc0 = 0, ovr0 = 0, brk0 = 0, ovr1 = 0, brk1 = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } word_t;
  word_t q0[$];
  word_t q1[$];

  typedef struct {
    int         which;
    logic [7:0] d;
    bit         flip;
    bit         stop_low;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;
  vec_t vecs[6];

  uart_receiver u_dut0 (
    .clk(clk), .rst(rst), .uart_rx(rx0), .rx_data(data0), .rx_parity_err(perr0),
    .rx_frame_err(ferr0), .rx_valid(val0), .rx_ready(rdy0), .overrun_err(ovr0_s),
    .break_det(brk0_s)
  );

  uart_receiver #(.PARITY(2)) u_dut1 (
    .clk(clk), .rst(rst), .uart_rx(rx1), .rx_data(data1), .rx_parity_err(perr1),
    .rx_frame_err(ferr1), .rx_valid(val1), .rx_ready(rdy1), .overrun_err(ovr1_s),
    .break_det(brk1_s)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    word_t w;
    if (val0) vcyc0++;
    if (val0 && rdy0) begin
      w.d = data0; w.pe = perr0; w.fe = ferr0;
      q0.push_back(w);
    end
    if (val1 && rdy1) begin
      w.d = data1; w.pe = perr1; w.fe = ferr1;
      q1.push_back(w);
    end
    if (ovr0_s) ovr0++;
    if (brk0_s) brk0++;
    if (ovr1_s) ovr1++;
    if (brk1_s) brk1++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx0 = v;
    else rx1 = v;
  endtask

  // pmode: 0 none, 1 odd, 2 even; flip inverts the correct parity bit.
  task automatic send_frame(input int which, input logic [7:0] d, input int pmode,
                            input bit flip, input bit stop_low);
    logic pb;
    drive(which, 1'b0);
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(which, d[i]);
      wait_clk(BIT);
    end
    if (pmode != 0) begin
      pb = (^d) ^ (pmode == 1) ^ flip;
      drive(which, pb);
      wait_clk(BIT);
    end
    drive(which, ~stop_low);
    wait_clk(BIT);
    drive(which, 1'b1);
  endtask

  task automatic expect_word(input int which, input string name, input logic [7:0] ed,
                             input logic epe, input logic efe);
    word_t w;
    bit    ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      if (which == 0 ? (q0.size() != 0) : (q1.size() != 0)) ok = 1'b1;
      else wait_clk(1);
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no word within 3000 cycles, expected data 0x%0h", name, ed);
    end else begin
      if (which == 0) w = q0.pop_front();
      else w = q1.pop_front();
      check({name, "_data"}, 32'(w.d), 32'(ed));
      check({name, "_perr"}, 32'(w.pe), 32'(epe));
      check({name, "_ferr"}, 32'(w.fe), 32'(efe));
    end
  endtask

  initial begin
    int b0;
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{1, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[2] = '{1, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{1, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
    vecs[5] = '{1, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1};

    wait_clk(3);
    check("rst_valid", 32'(val0), 32'd0);
    check("rst_data", 32'(data0), 32'd0);
    check("rst_flags", {28'd0, perr0, ferr0, ovr0_s, brk0_s}, 32'd0);
    rst = 1'b0;
    wait_clk(20);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].which, vecs[i].d, (vecs[i].which == 1) ? 2 : 0,
                 vecs[i].flip, vecs[i].stop_low);
      expect_word(vecs[i].which, $sformatf("vec%0d", i), vecs[i].exp_d,
                  vecs[i].exp_pe, vecs[i].exp_fe);
      wait_clk(2 * BIT);
    end
    check("valid_one_cycle", 32'(vcyc0), 32'd2);
    check("no_pulses", 32'(ovr0 + brk0 + ovr1 + brk1), 32'd0);

    // overrun: second frame dropped while the first is held
    rdy0 = 1'b0;
    send_frame(0, 8'h11, 0, 1'b0, 1'b0);
    wait_clk(BIT);
    send_frame(0, 8'h22, 0, 1'b0, 1'b0);
    wait_clk(BIT);
    check("ovr_valid", 32'(val0), 32'd1);
    check("ovr_held", 32'(data0), 32'h11);
    check("ovr_pulse", 32'(ovr0), 32'd1);
    rdy0 = 1'b1;
    expect_word(0, "ovr_word", 8'h11, 1'b0, 1'b0);
    wait_clk(3 * BIT);
    check("ovr_dropped", 32'(q0.size()), 32'd0);

    // back-to-back frames with no idle gap
    send_frame(0, 8'hFF, 0, 1'b0, 1'b0);
    send_frame(0, 8'h00, 0, 1'b0, 1'b0);
    expect_word(0, "b2b_ff", 8'hFF, 1'b0, 1'b0);
    expect_word(0, "b2b_00", 8'h00, 1'b0, 1'b0);
    wait_clk(2 * BIT);

    // break: 20 bit times low
    b0 = brk0;
    rx0 = 1'b0;
    wait_clk(20 * BIT);
    rx0 = 1'b1;
    wait_clk(3 * BIT);
    check("brk_pulse", 32'(brk0 - b0), 32'd1);
    check("brk_noword", 32'(q0.size()), 32'd0);
    send_frame(0, 8'h12, 0, 1'b0, 1'b0);
    expect_word(0, "after_brk", 8'h12, 1'b0, 1'b0);
    wait_clk(2 * BIT);

    // two-cycle glitch on idle line
    rx0 = 1'b0;
    wait_clk(2);
    rx0 = 1'b1;
    wait_clk(3 * BIT);
    check("glitch_noword", 32'(q0.size()), 32'd0);
    check("glitch_nobrk", 32'(brk0 - b0), 32'd1);

    // reset mid-frame with the line still low after release
    rx0 = 1'b0;
    wait_clk(3 * BIT);
    rst = 1'b1;
    wait_clk(4);
    check("midrst_valid", 32'(val0), 32'd0);
    rst = 1'b0;
    wait_clk(BIT);
    rx0 = 1'b1;
    wait_clk(3 * BIT);
    check("midrst_noword", 32'(q0.size()), 32'd0);
    send_frame(0, 8'h7E, 0, 1'b0, 1'b0);
    expect_word(0, "after_rst", 8'h7E, 1'b0, 1'b0);
    wait_clk(2 * BIT);
    check("after_rst_only", 32'(q0.size()), 32'd0);
    check("end_brk", 32'(brk0 - b0), 32'd1);
    check("end_dut1_pulses", 32'(ovr1 + brk1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Synthesizable, parametrised UART receiver: the receive side our TX/RX benches drive at the pins, turned into hardware. It oversamples a synchronised `uart_rx` line, majority-votes each bit and checks configurable parity and stop bits. It flags framing, parity, overrun and break conditions and presents each received word on a valid/ready interface to the downstream FIFO or CPU bus.

## Interface
- `CLK_HZ`, 12_000_000, system clock frequency.
- `BAUDRATE`, 115200, line rate.
- `OVERSAMPLE`, 8, ticks per bit; even, ≥4.
- `SYNC_DEPTH`, 3, input synchroniser flops; ≥2.
- `DATA_BITS`, 8, data width, 5..9.
- `PARITY`, 0, 0 none / 1 odd / 2 even.
- `STOP_BITS`, 1, 1 or 2.
- `clk  input  1  system clock`
- `rst  input  1  reset; asynchronous, active-high`
- `uart_rx  input  1  serial line, idle high, LSB first`
- `rx_data  output  DATA_BITS  received word; valid while rx_valid`
- `rx_parity_err  output  1  sideband, qualified by rx_valid`
- `rx_frame_err  output  1  sideband, qualified by rx_valid`
- `rx_valid  output  1  word available`
- `rx_ready  input  1  consumer accepts word`
- `overrun_err  output  1  one-cycle pulse, completed frame dropped`
- `break_det  output  1  one-cycle pulse, break condition detected`

## Operation
- Tick divisor: DIV = round(CLK_HZ / (BAUDRATE·OVERSAMPLE)).
- Elaboration `$error` if DIV < 1, or if the resulting bit-rate error exceeds 2%.
- Synchroniser: SYNC_DEPTH flops, reset to 1. All logic uses the synchronised signal `rxs`.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE: on falling edge of `rxs`, restart the tick divider and the sample counter, then go to START.
  - Sample counter counts ticks 0..OVERSAMPLE-1 within each bit.
  - Bit value = majority of `rxs` at ticks M-1, M and M+1, where M = OVERSAMPLE/2.
  - START: voted bit 1 → false start, return to IDLE, no outputs. Voted bit 0 → DATA.
  - DATA: shift DATA_BITS bits LSB first, then go to PAR, or to STOP if PARITY=0.
  - PAR: parity error if XOR(data, parity bit) ≠ 1 for odd, or ≠ 0 for even.
  - STOP: vote STOP_BITS bits. Framing error if any stop bit votes 0.
  - Leave STOP at the final stop bit's tick M+1, not at its end, so a start bit that follows back-to-back is caught.
- Break: data all 0, parity bit 0 (if present) and first stop bit 0.
  - Pulse `break_det`, deliver no word, enter BRK.
  - BRK: wait for `rxs` high for one full bit time, then go to IDLE.
- Delivery:
  - When a frame completes and rx_valid is low: load rx_data and both error flags, set rx_valid.
  - When a frame completes and rx_valid is high with rx_ready low: drop the new frame, pulse `overrun_err`, leave the held word unchanged.
  - When a frame completes while rx_valid && rx_ready in the same cycle: accept the old word and load the new one; no overrun.
- Reset values:
  - Outputs: rx_valid 0, rx_data 0, all error and pulse outputs 0.
  - Internal: FSM in IDLE, synchroniser all 1.
- Reset asserted mid-frame aborts the frame. After release, the FSM must see `rxs` high before it arms the start edge.

## Timing
- Start edge seen SYNC_DEPTH+1 cycles after the `uart_rx` edge.
- rx_valid rises the cycle after the final stop bit's M+1 sample.
- Handshake completes on any clk edge with rx_valid && rx_ready. rx_valid falls the next cycle unless a new word loads in that same cycle.
- rx_data is stable while rx_valid is high and rx_ready is low.
- `overrun_err` and `break_det` are exactly 1 cycle wide.
- Defaults: DIV=13, 104 clk/bit. A full 8N1 frame reaches rx_valid about 9.5·104 + 4 cycles after the start edge.

## Structure
- `uart_pkg`:
  - parity enum {PAR_NONE, PAR_ODD, PAR_EVEN}
  - rx FSM state enum
  - function `uart_div(clk_hz, baud, os)` shared with the future transmitter
- Sub-module `uart_tick_gen`: DIV counter with a synchronous `restart` input and a one-cycle `tick` output; reused by the TX.

## Test plan
- 8N1 defaults: send 0xA5, rx_ready=1 → rx_data=0xA5, rx_valid for 1 cycle, no error flags.
- PARITY=2: send 0x3C with correct parity bit → parity_err=0. Send 0x3C with the parity bit flipped → rx_data=0x3C with rx_parity_err=1.
- Stop bit forced low on 0x55 → rx_frame_err=1, rx_data=0x55.
- Break:
  - line low for 20 bit times → exactly one break_det pulse, no rx_valid;
  - then send 0x12 → delivered cleanly.
- Overrun and back-to-back:
  - rx_ready=0, send 0x11 then 0x22 → rx_data stays 0x11, overrun_err pulses once;
  - back-to-back 0xFF then 0x00 with rx_ready=1 → both received.
- Glitch rejection:
  - 2-cycle low glitch on idle line → no output;
  - rst asserted mid-frame, then send 0x7E → only 0x7E received.
